usb_wire_tx_serializer: RTL

Transmit-side line-rate serializer for the USB serial interface engine. Accepts 2-bit symbol/drive-enable entries from the SIE transmitter through a 4-entry FIFO and emits one entry per USB bit period onto the wire driver outputs at full-speed (4 clocks/bit) or low-speed (32 clocks/bit) rate. It also generates `TxWireActiveDrive`, which the receive path uses to suppress edge detection while this block drives the bus.

---
 rtl/usb_wire_tx_serializer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/usb_wire_tx_serializer.sv
// Transmit-side line-rate serializer: queues 2-bit symbols plus drive enable in a
// 4-deep FIFO and plays one entry per USB bit period onto the wire driver.
module usb_wire_tx_serializer #(
    parameter int FS_BIT_CLKS = 4,
    parameter int LS_BIT_CLKS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] TxBitsIn,
    input  logic       TxCtrlIn,
    input  logic       SIETxWEn,
    output logic       SIETxRdy,
    input  logic       fullSpeedRate,
    output logic [1:0] TxBitsOut,
    output logic       TxCtrlOut,
    output logic       TxWireActiveDrive,
    output logic       TxDataOutTick,
    output logic       TxUnderflow
);

    localparam int CW = 5;
    localparam int GMAX = (FS_BIT_CLKS > LS_BIT_CLKS) ? FS_BIT_CLKS : LS_BIT_CLKS;
    localparam int GW = $clog2(GMAX + 1);

    localparam logic [CW-1:0] FS_LAST  = CW'(FS_BIT_CLKS - 1);
    localparam logic [CW-1:0] LS_LAST  = CW'(LS_BIT_CLKS - 1);
    localparam logic [GW-1:0] FS_GUARD = GW'(FS_BIT_CLKS);
    localparam logic [GW-1:0] LS_GUARD = GW'(LS_BIT_CLKS);

    // Each entry is {drive enable, D+, D-}
    logic [2:0]    fifo_mem [4];
    logic [2:0]    count_q, count_d;
    logic [1:0]    wr_idx_q, wr_idx_d;
    logic [1:0]    rd_idx_q, rd_idx_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          rate_q, rate_d;
    logic [1:0]    bits_q, bits_d;
    logic          ctrl_q, ctrl_d;
    logic          tick_q, tick_d;
    logic          underflow_q, underflow_d;

    logic          idle;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          bit_tick;
    logic          underflow_now;
    logic          ctrl_fall;
    logic [2:0]    head;
    logic [CW-1:0] bit_last;
    logic [GW-1:0] guard_len;

    assign full     = (count_q == 3'd4);
    assign empty    = (count_q == 3'd0);
    assign idle     = empty && !ctrl_q && (guard_q == '0);
    assign bit_last = rate_q ? FS_LAST : LS_LAST;
    assign guard_len = rate_q ? FS_GUARD : LS_GUARD;
    assign bit_tick = !idle && (bit_cnt_q == bit_last);
    assign head     = fifo_mem[rd_idx_q];

    assign push          = SIETxWEn && !full;
    assign pop           = bit_tick && !empty;
    assign underflow_now = bit_tick && empty && ctrl_q;
    // Drive enable falling edge arms the guard that keeps the receiver blind
    assign ctrl_fall     = ctrl_q && ((pop && !head[2]) || underflow_now);

    assign SIETxRdy          = !full;
    assign TxBitsOut         = bits_q;
    assign TxCtrlOut         = ctrl_q;
    assign TxWireActiveDrive = ctrl_q | (guard_q != '0);
    assign TxDataOutTick     = tick_q;
    assign TxUnderflow       = underflow_q;

    always_comb begin
        count_d     = count_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        bit_cnt_d   = bit_cnt_q;
        guard_d     = guard_q;
        rate_d      = rate_q;
        bits_d      = bits_q;
        ctrl_d      = ctrl_q;
        tick_d      = tick_q;
        underflow_d = underflow_now;

        if (push) begin
            wr_idx_d = wr_idx_q + 2'd1;
        end
        if (pop) begin
            rd_idx_d = rd_idx_q + 2'd1;
            bits_d   = head[1:0];
            ctrl_d   = head[2];
            tick_d   = !tick_q;
        end
        if (underflow_now) begin
            ctrl_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        // Rate is only re-sampled between packets so a packet never changes speed
        if (idle) begin
            bit_cnt_d = '0;
            rate_d    = fullSpeedRate;
        end else if (bit_tick) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
        end

        if (ctrl_fall) begin
            guard_d = guard_len;
        end else if (guard_q != '0) begin
            guard_d = guard_q - GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx_q] <= {TxCtrlIn, TxBitsIn};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 3'd0;
            wr_idx_q    <= 2'd0;
            rd_idx_q    <= 2'd0;
            bit_cnt_q   <= '0;
            guard_q     <= '0;
            rate_q      <= 1'b1;
            bits_q      <= 2'b00;
            ctrl_q      <= 1'b0;
            tick_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            guard_q     <= guard_d;
            rate_q      <= rate_d;
            bits_q      <= bits_d;
            ctrl_q      <= ctrl_d;
            tick_q      <= tick_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
